master_out_port: RTL and testbench

MASTER_OUT_PORT -- requirements
Module: master_out_port

---
 rtl/master_out_port.sv | 206 ++++++++++++++++++++
 tb/tb_master_out_port.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/master_out_port.sv
// master_out_port: serial-bus master that captures one request and shifts its
// address and data out LSB first, one bit per clk after the m_valid/s_ready
// handshake.
// Build option: define MASTER_OUT_BURST_EN to add write bursts. In a burst,
// each extra beat fetches one byte from the wd_* stream and sends it as a
// data-only beat.
//
// state      | meaning
// IDLE       | req_ready high, waiting for a request
// HS_WAIT    | m_valid high, address/data bit 0 held until s_ready
// ADDR_TX    | address bits 1..11, write data bits 1..7 (zero afterwards)
// BEAT_FETCH | wd_ready high, waiting for the next burst byte
// BEAT_HS    | m_valid high, burst byte bit 0 held until s_ready
// DATA_TX    | burst byte bits 1..7, tx_address low
module master_out_port (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [11:0] req_addr,
   input  logic [7:0]  req_wdata,
   input  logic        req_write,
   input  logic        req_read,
   input  logic [12:0] req_burst,
   input  logic        wd_valid,
   output logic        wd_ready,
   input  logic [7:0]  wd_data,
   output logic        m_valid,
   input  logic        s_ready,
   output logic        tx_address,
   output logic        tx_data,
   output logic        write_enable,
   output logic        read_enable,
   output logic [12:0] burst,
   output logic        tx_done
);

`ifdef MASTER_OUT_BURST_EN
   typedef enum logic [2:0] {IDLE, HS_WAIT, ADDR_TX, BEAT_FETCH, BEAT_HS, DATA_TX} state_t;
`else
   typedef enum logic [1:0] {IDLE, HS_WAIT, ADDR_TX} state_t;
`endif

   state_t      state_q, state_d;
   logic [11:0] addr_sh;
   logic [7:0]  data_sh;
   logic [3:0]  bit_cnt;
   logic        bit_tc;
   logic        wr_q;
   logic        rd_q;
   logic        tx_done_q;

   assign bit_tc       = (bit_cnt == 4'd0);
   assign write_enable = wr_q;
   assign read_enable  = rd_q;
   assign tx_done      = tx_done_q;

`ifdef MASTER_OUT_BURST_EN
   logic [12:0] burst_q;
   logic [11:0] beat_cnt;
   logic        more_beats;

   // Beats already sent beyond the first are counted up and compared with the
   // requested extra-beat count; a zero count therefore means a single beat.
   assign more_beats = wr_q && burst_q[0] && (beat_cnt != burst_q[12:1]);
   assign burst      = burst_q;
`else
   logic unused_burst_inputs;

   assign unused_burst_inputs = ^{req_burst, wd_valid, wd_data};
   assign burst               = '0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and bus outputs; bit 0 is presented while waiting for s_ready
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      m_valid    = 1'b0;
      wd_ready   = 1'b0;
      tx_address = 1'b0;
      tx_data    = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = HS_WAIT;
         end
         HS_WAIT: begin
            m_valid    = 1'b1;
            tx_address = addr_sh[0];
            tx_data    = data_sh[0];
            if (s_ready) state_d = ADDR_TX;
         end
         ADDR_TX: begin
            tx_address = addr_sh[0];
            tx_data    = data_sh[0];
            if (bit_tc) begin
`ifdef MASTER_OUT_BURST_EN
               state_d = more_beats ? BEAT_FETCH : IDLE;
`else
               state_d = IDLE;
`endif
            end
         end
`ifdef MASTER_OUT_BURST_EN
         BEAT_FETCH: begin
            wd_ready = 1'b1;
            if (wd_valid) state_d = BEAT_HS;
         end
         BEAT_HS: begin
            m_valid = 1'b1;
            tx_data = data_sh[0];
            if (s_ready) state_d = DATA_TX;
         end
         DATA_TX: begin
            tx_data = data_sh[0];
            if (bit_tc) state_d = more_beats ? BEAT_FETCH : IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Request capture, bit shifters, bit down-counter and the tx_done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_sh   <= '0;
         data_sh   <= '0;
         bit_cnt   <= '0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         tx_done_q <= 1'b0;
`ifdef MASTER_OUT_BURST_EN
         burst_q   <= '0;
         beat_cnt  <= '0;
`endif
      end else begin
         tx_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  addr_sh  <= req_addr;
                  // Reads keep the data line low by shifting out zeros.
                  data_sh  <= req_write ? req_wdata : 8'h00;
                  wr_q     <= req_write;
                  rd_q     <= req_read && !req_write;
`ifdef MASTER_OUT_BURST_EN
                  burst_q  <= req_burst;
                  beat_cnt <= '0;
`endif
               end
            end
            HS_WAIT: begin
               if (s_ready) begin
                  addr_sh <= {1'b0, addr_sh[11:1]};
                  data_sh <= {1'b0, data_sh[7:1]};
                  bit_cnt <= 4'd10;
               end
            end
            ADDR_TX: begin
               addr_sh <= {1'b0, addr_sh[11:1]};
               data_sh <= {1'b0, data_sh[7:1]};
               if (bit_tc) begin
                  tx_done_q <= 1'b1;
`ifdef MASTER_OUT_BURST_EN
                  if (more_beats) beat_cnt <= beat_cnt + 12'd1;
`endif
               end else begin
                  bit_cnt <= bit_cnt - 4'd1;
               end
            end
`ifdef MASTER_OUT_BURST_EN
            BEAT_FETCH: begin
               if (wd_valid) data_sh <= wd_data;
            end
            BEAT_HS: begin
               if (s_ready) begin
                  data_sh <= {1'b0, data_sh[7:1]};
                  bit_cnt <= 4'd6;
               end
            end
            DATA_TX: begin
               data_sh <= {1'b0, data_sh[7:1]};
               if (bit_tc) begin
                  tx_done_q <= 1'b1;
                  if (more_beats) beat_cnt <= beat_cnt + 12'd1;
               end else begin
                  bit_cnt <= bit_cnt - 4'd1;
               end
            end
`endif
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_master_out_port.sv
// Bench for master_out_port. The stimulus process queues the expected serial
// beats (address bits, data bits and handshake-to-tx_done latency). A monitor
// rebuilds each beat from the bus and checks it against the queue.
module tb_master_out_port;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid, req_ready;
   logic [11:0] req_addr;
   logic [7:0]  req_wdata;
   logic        req_write, req_read;
   logic [12:0] req_burst;
   logic        wd_valid, wd_ready;
   logic [7:0]  wd_data;
   logic        m_valid, s_ready;
   logic        tx_address, tx_data;
   logic        write_enable, read_enable;
   logic [12:0] burst;
   logic        tx_done;

`ifdef MASTER_OUT_BURST_EN
   localparam bit BURST_EN = 1'b1;
`else
   localparam bit BURST_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   master_out_port dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_write(req_write), .req_read(req_read), .req_burst(req_burst),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
      .m_valid(m_valid), .s_ready(s_ready),
      .tx_address(tx_address), .tx_data(tx_data),
      .write_enable(write_enable), .read_enable(read_enable),
      .burst(burst), .tx_done(tx_done)
   );

   typedef struct {
      logic [11:0] addr;
      logic [7:0]  data;
      int          len;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   bit    wd_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [11:0] a, input logic [7:0] d, input int len);
      beat_t b;
      b.addr = a;
      b.data = d;
      b.len  = len;
      exp_q.push_back(b);
   endtask

   // Monitor: rebuild each beat from the handshake cycle to its tx_done pulse
   bit          in_beat = 1'b0;
   int          cnt;
   logic [11:0] addr_acc;
   logic [7:0]  data_acc;
   bit          tail_bad;
   beat_t       mon_e;

   always @(negedge clk) begin
      if (wd_ready) wd_seen = 1'b1;
      if (reset) begin
         in_beat = 1'b0;
      end else if (in_beat) begin
         cnt++;
         if (tx_done) begin
            in_beat = 1'b0;
            if (exp_q.size() == 0) begin
               check("beat_unexpected", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("beat_addr", {20'd0, addr_acc}, {20'd0, mon_e.addr});
               check("beat_data", {24'd0, data_acc}, {24'd0, mon_e.data});
               check("beat_len", cnt, mon_e.len);
               check("beat_tail_zero", {31'd0, tail_bad}, 0);
            end
         end else begin
            if (cnt < 12) addr_acc = {tx_address, addr_acc[11:1]};
            else if (tx_address) tail_bad = 1'b1;
            if (cnt < 8) data_acc = {tx_data, data_acc[7:1]};
            else if (tx_data) tail_bad = 1'b1;
            if (cnt > 30) begin
               check("beat_done_timeout", 0, 1);
               in_beat = 1'b0;
            end
         end
      end else begin
         if (tx_done) check("stray_tx_done", 1, 0);
         if (m_valid && s_ready) begin
            in_beat  = 1'b1;
            cnt      = 0;
            addr_acc = {tx_address, 11'd0};
            data_acc = {tx_data, 7'd0};
            tail_bad = 1'b0;
         end
      end
   end

   // Called at posedge+1 with the DUT idle; returns at posedge+1 after capture
   task automatic send_req(input logic [11:0] a, input logic [7:0] d,
                           input logic w, input logic r, input logic [12:0] b);
      int n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) check("req_ready_timeout", 0, 1);
      req_valid = 1'b1;
      req_addr  = a;
      req_wdata = d;
      req_write = w;
      req_read  = r;
      req_burst = b;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_read  = 1'b0;
      req_burst = '0;
   endtask

   // Returns at the negedge where tx_done is seen
   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tx_done && n < 60);
      if (!tx_done) check("tx_done_timeout", 0, 1);
   endtask

   task automatic idle_check();
      @(negedge clk);
      check("idle_req_ready", req_ready, 1);
      check("idle_m_valid", m_valid, 0);
      @(posedge clk); #1;
   endtask

   task automatic feed(input logic [7:0] b);
      int n = 0;
      wd_valid = 1'b1;
      wd_data  = b;
      do begin
         @(negedge clk);
         n++;
      end while (!wd_ready && n < 60);
      if (!wd_ready) check("wd_ready_timeout", 0, 1);
      @(posedge clk); #1;
      wd_valid = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid = 1'b0; req_addr = '0; req_wdata = '0;
      req_write = 1'b0; req_read = 1'b0; req_burst = '0;
      wd_valid = 1'b0; wd_data = '0; s_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_m_valid", m_valid, 0);
      check("rst_tx_address", tx_address, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_done", tx_done, 0);
      check("rst_write_enable", write_enable, 0);
      check("rst_read_enable", read_enable, 0);
      check("rst_burst", {19'd0, burst}, 0);
      check("rst_wd_ready", wd_ready, 0);
      @(posedge clk); #1;

      // Single write 0xA53 / 0x3C
      push_exp(12'hA53, 8'h3C, 12);
      send_req(12'hA53, 8'h3C, 1'b1, 1'b0, 13'd0);
      @(negedge clk);
      check("wr_write_enable", write_enable, 1);
      check("wr_read_enable", read_enable, 0);
      wait_done();
      idle_check();

      // Single read 0x001: data line stays low
      push_exp(12'h001, 8'h00, 12);
      send_req(12'h001, 8'hFF, 1'b0, 1'b1, 13'd0);
      @(negedge clk);
      check("rd_read_enable", read_enable, 1);
      check("rd_write_enable", write_enable, 0);
      wait_done();
      idle_check();

      // Write and read both high: write wins
      push_exp(12'h3C7, 8'h5A, 12);
      send_req(12'h3C7, 8'h5A, 1'b1, 1'b1, 13'd0);
      @(negedge clk);
      check("both_write_enable", write_enable, 1);
      check("both_read_enable", read_enable, 0);
      wait_done();
      idle_check();

      // Slave stalls five cycles: m_valid and bit 0 held
      s_ready = 1'b0;
      push_exp(12'h6B5, 8'h81, 12);
      send_req(12'h6B5, 8'h81, 1'b1, 1'b0, 13'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_m_valid", m_valid, 1);
         check("stall_addr_bit0", tx_address, 1);
         check("stall_data_bit0", tx_data, 1);
         @(posedge clk); #1;
      end
      s_ready = 1'b1;
      wait_done();
      idle_check();

      // Burst enabled with zero extra beats: single beat
      push_exp(12'h123, 8'hC3, 12);
      send_req(12'h123, 8'hC3, 1'b1, 1'b0, 13'h001);
      @(negedge clk);
      check("burst0_burst", {19'd0, burst}, BURST_EN ? 32'h1 : 32'h0);
      wait_done();
      idle_check();

      // Read burst: slave sequences it, one beat here
      push_exp(12'h456, 8'h00, 12);
      send_req(12'h456, 8'h00, 1'b0, 1'b1, 13'h005);
      wait_done();
      idle_check();

      // Write burst with two extra beats
      push_exp(12'h0F0, 8'hA5, 12);
`ifdef MASTER_OUT_BURST_EN
      push_exp(12'h000, 8'h11, 8);
      push_exp(12'h000, 8'h22, 8);
      send_req(12'h0F0, 8'hA5, 1'b1, 1'b0, 13'h005);
      @(negedge clk);
      check("wburst_burst", {19'd0, burst}, 32'h5);
      fork
         begin
            feed(8'h11);
            feed(8'h22);
         end
         begin
            wait_done();
            wait_done();
            wait_done();
         end
      join
      idle_check();
`else
      wd_valid = 1'b1;
      wd_data  = 8'h11;
      send_req(12'h0F0, 8'hA5, 1'b1, 1'b0, 13'h005);
      @(negedge clk);
      check("wburst_burst", {19'd0, burst}, 32'h0);
      wait_done();
      idle_check();
      repeat (10) @(posedge clk);
      #1 wd_valid = 1'b0;
`endif

      // Reset during ADDR_TX bit 6 abandons the transfer
      send_req(12'hFFF, 8'hFF, 1'b1, 1'b0, 13'd0);
      repeat (6) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("midrst_req_ready", req_ready, 1);
      check("midrst_m_valid", m_valid, 0);
      check("midrst_tx_address", tx_address, 0);
      check("midrst_tx_done", tx_done, 0);
      check("midrst_write_enable", write_enable, 0);
      @(posedge clk); #1;

      // Recovery after the abandoned transfer
      push_exp(12'h800, 8'h80, 12);
      send_req(12'h800, 8'h80, 1'b1, 1'b0, 13'd0);
      wait_done();
      idle_check();

      repeat (5) @(posedge clk);
      @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      check("wd_ready_activity", {31'd0, wd_seen}, BURST_EN ? 32'h1 : 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
